// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions, issue states.
package proc_pkg;

    localparam logic [3:0] OP_STORE  = 4'b1100;
    localparam logic [3:0] OP_LOAD_A = 4'b1111;
    localparam logic [3:0] OP_LOAD_B = 4'b1101;

    localparam int unsigned INSTR_W = 20;
    localparam int unsigned OPC_HI  = 19;
    localparam int unsigned OPC_LO  = 16;
    localparam int unsigned RD_HI   = 15;
    localparam int unsigned RD_LO   = 12;
    localparam int unsigned RS_HI   = 11;
    localparam int unsigned RS_LO   = 8;
    localparam int unsigned RT_HI   = 7;
    localparam int unsigned RT_LO   = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } issue_state_t;

endpackage

// File: rtl/wb_pending_counter.sv
// One per-register pending-write counter: saturating up/down with clear.
module wb_pending_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic zero,
    output logic sat,
    output logic underflow
);

    logic [CNT_W-1:0] count;

    assign zero      = (count == '0);
    assign sat       = (count == '1);
    // A retire with nothing pending; a same-cycle issue cancels it out instead.
    assign underflow = dec & ~inc & ~clr & zero;

    // Count update: clear wins, simultaneous inc/dec cancel, both ends hold.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !sat) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_hazard_scoreboard.sv
// Issue-side hazard scoreboard: tracks pending register writes and stalls issue.
module wb_hazard_scoreboard
    import proc_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned CNT_W = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               issue_valid,
    input  logic [INSTR_W-1:0] issue_instruction,
    output logic               issue_ready,
    input  logic               wb_enable,
    input  logic [3:0]         wb_address,
    input  logic               flush,
    output logic [NREGS-1:0]   busy_mask,
    output logic               stall,
    output logic [15:0]        stall_cycles,
    output logic               underflow_err
);

    logic [3:0] opcode, rd, rs, rt;
    logic       is_store, writer, hazard, fire;

    logic [NREGS-1:0] inc_vec, dec_vec, zero_vec, sat_vec, uf_vec;

    issue_state_t state;

    assign opcode = issue_instruction[OPC_HI:OPC_LO];
    assign rd     = issue_instruction[RD_HI:RD_LO];
    assign rs     = issue_instruction[RS_HI:RS_LO];
    assign rt     = issue_instruction[RT_HI:RT_LO];

    assign is_store = (opcode == OP_STORE);
    assign writer   = ~is_store;

    // Conservative check from registered counts only; no write-back bypass.
    assign hazard = ~zero_vec[rs] | ~zero_vec[rt]
                  | (is_store & ~zero_vec[rd])
                  | (writer & sat_vec[rd]);

    assign issue_ready = ~hazard;
    assign stall       = issue_valid & hazard;
    assign fire        = issue_valid & ~hazard & ~flush & writer;
    assign busy_mask   = ~zero_vec;

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        assign inc_vec[r] = fire && (rd == 4'(r));
        assign dec_vec[r] = wb_enable && !flush && (wb_address == 4'(r));

        wb_pending_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock     (clock),
            .resetn    (resetn),
            .inc       (inc_vec[r]),
            .dec       (dec_vec[r]),
            .clr       (flush),
            .zero      (zero_vec[r]),
            .sat       (sat_vec[r]),
            .underflow (uf_vec[r])
        );
    end

    // Stall-accounting FSM plus sticky error and saturating stall counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= RUN;
            stall_cycles  <= '0;
            underflow_err <= 1'b0;
        end else begin
            unique case (state)
                RUN:  if (issue_valid && hazard && !flush) state <= HOLD;
                HOLD: if (!hazard || !issue_valid || flush) state <= RUN;
                default: state <= RUN;
            endcase
            if (stall && !flush && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (|uf_vec) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_hazard_scoreboard.sv
// Directed self-checking bench for wb_hazard_scoreboard.
module tb_wb_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        resetn;
    logic        issue_valid;
    logic [19:0] issue_instruction;
    logic        issue_ready;
    logic        wb_enable;
    logic [3:0]  wb_address;
    logic        flush;
    logic [15:0] busy_mask;
    logic        stall;
    logic [15:0] stall_cycles;
    logic        underflow_err;

    int compared = 0;
    int mismatched = 0;

    wb_hazard_scoreboard #(
        .NREGS (16),
        .CNT_W (2)
    ) dut (
        .clock             (clock),
        .resetn            (resetn),
        .issue_valid       (issue_valid),
        .issue_instruction (issue_instruction),
        .issue_ready       (issue_ready),
        .wb_enable         (wb_enable),
        .wb_address        (wb_address),
        .flush             (flush),
        .busy_mask         (busy_mask),
        .stall             (stall),
        .stall_cycles      (stall_cycles),
        .underflow_err     (underflow_err)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt, 4'h0};
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        issue_valid = 1'b0;
        issue_instruction = '0;
        wb_enable = 1'b0;
        wb_address = '0;
        flush = 1'b0;
        #3;
        compared++;
        if (busy_mask !== 16'h0) begin
            mismatched++; $display("FAIL reset_busy got %h want 0000", busy_mask);
        end
        compared++;
        if (issue_ready !== 1'b1 || stall !== 1'b0) begin
            mismatched++; $display("FAIL reset_ready got rdy=%b stall=%b want 1/0", issue_ready, stall);
        end
        compared++;
        if (stall_cycles !== 16'd0 || underflow_err !== 1'b0) begin
            mismatched++; $display("FAIL reset_stats got sc=%0d uf=%b want 0/0", stall_cycles, underflow_err);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        issue_valid = 1'b1;
        issue_instruction = ins(4'b1111, 4'd3, 4'd0, 4'd0);
        tick();
        compared++;
        if (busy_mask !== 16'h0008) begin
            mismatched++; $display("FAIL lu_busy got %h want 0008", busy_mask);
        end
        issue_instruction = ins(4'b0000, 4'd1, 4'd3, 4'd0);
        #1;
        compared++;
        if (issue_ready !== 1'b0 || stall !== 1'b1) begin
            mismatched++; $display("FAIL lu_stall got rdy=%b stall=%b want 0/1", issue_ready, stall);
        end
        repeat (3) tick();
        compared++;
        if (stall_cycles !== 16'd3) begin
            mismatched++; $display("FAIL lu_count got %0d want 3", stall_cycles);
        end
        wb_enable = 1'b1;
        wb_address = 4'd3;
        #1;
        compared++;
        if (issue_ready !== 1'b0) begin
            mismatched++; $display("FAIL lu_nobypass got %b want 0", issue_ready);
        end
        tick();
        wb_enable = 1'b0;
        compared++;
        if (issue_ready !== 1'b1 || stall_cycles !== 16'd4) begin
            mismatched++; $display("FAIL lu_release got rdy=%b sc=%0d want 1/4", issue_ready, stall_cycles);
        end
        tick();
        issue_valid = 1'b0;
        compared++;
        if (busy_mask !== 16'h0002) begin
            mismatched++; $display("FAIL lu_fire got %h want 0002", busy_mask);
        end
        wb_enable = 1'b1;
        wb_address = 4'd1;
        tick();
        wb_enable = 1'b0;
    endtask

    task automatic test_store();
        issue_valid = 1'b1;
        issue_instruction = ins(4'b0001, 4'd5, 4'd0, 4'd0);
        tick();
        issue_instruction = ins(4'b1100, 4'd5, 4'd0, 4'd0);
        #1;
        compared++;
        if (issue_ready !== 1'b0 || busy_mask !== 16'h0020) begin
            mismatched++; $display("FAIL st_hold got rdy=%b busy=%h want 0/0020", issue_ready, busy_mask);
        end
        tick();
        wb_enable = 1'b1;
        wb_address = 4'd5;
        tick();
        wb_enable = 1'b0;
        compared++;
        if (issue_ready !== 1'b1) begin
            mismatched++; $display("FAIL st_release got %b want 1", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        compared++;
        if (busy_mask !== 16'h0000 || stall_cycles !== 16'd6) begin
            mismatched++; $display("FAIL st_issue got busy=%h sc=%0d want 0000/6", busy_mask, stall_cycles);
        end
    endtask

    task automatic test_saturation();
        issue_valid = 1'b1;
        issue_instruction = ins(4'b0010, 4'd7, 4'd0, 4'd0);
        repeat (3) tick();
        compared++;
        if (busy_mask !== 16'h0080 || issue_ready !== 1'b0) begin
            mismatched++; $display("FAIL sat_full got busy=%h rdy=%b want 0080/0", busy_mask, issue_ready);
        end
        tick();
        wb_enable = 1'b1;
        wb_address = 4'd7;
        tick();
        wb_enable = 1'b0;
        compared++;
        if (issue_ready !== 1'b1 || stall_cycles !== 16'd8) begin
            mismatched++; $display("FAIL sat_release got rdy=%b sc=%0d want 1/8", issue_ready, stall_cycles);
        end
        tick();
        issue_valid = 1'b0;
        compared++;
        if (issue_ready !== 1'b0) begin
            mismatched++; $display("FAIL sat_refill got %b want 0", issue_ready);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_fire_retire();
        issue_valid = 1'b1;
        issue_instruction = ins(4'b0011, 4'd2, 4'd0, 4'd0);
        tick();
        wb_enable = 1'b1;
        wb_address = 4'd2;
        tick();
        issue_valid = 1'b0;
        compared++;
        if (busy_mask !== 16'h0004) begin
            mismatched++; $display("FAIL fr_same got %h want 0004", busy_mask);
        end
        tick();
        wb_enable = 1'b0;
        compared++;
        if (busy_mask !== 16'h0000 || underflow_err !== 1'b0) begin
            mismatched++; $display("FAIL fr_count1 got busy=%h uf=%b want 0000/0", busy_mask, underflow_err);
        end
    endtask

    task automatic test_flush_underflow();
        issue_valid = 1'b1;
        issue_instruction = ins(4'b0100, 4'd1, 4'd0, 4'd0);
        tick();
        issue_instruction = ins(4'b0100, 4'd4, 4'd0, 4'd0);
        tick();
        compared++;
        if (busy_mask !== 16'h0012) begin
            mismatched++; $display("FAIL fl_pending got %h want 0012", busy_mask);
        end
        issue_instruction = ins(4'b0100, 4'd6, 4'd0, 4'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        compared++;
        if (busy_mask !== 16'h0000 || stall_cycles !== 16'd8) begin
            mismatched++; $display("FAIL fl_clear got busy=%h sc=%0d want 0000/8", busy_mask, stall_cycles);
        end
        wb_enable = 1'b1;
        wb_address = 4'd1;
        tick();
        wb_enable = 1'b0;
        compared++;
        if (underflow_err !== 1'b1 || busy_mask !== 16'h0000) begin
            mismatched++; $display("FAIL fl_underflow got uf=%b busy=%h want 1/0000", underflow_err, busy_mask);
        end
        repeat (2) tick();
        compared++;
        if (underflow_err !== 1'b1) begin
            mismatched++; $display("FAIL fl_sticky got %b want 1", underflow_err);
        end
    endtask

    task automatic test_async_reset();
        issue_valid = 1'b1;
        issue_instruction = ins(4'b0101, 4'd3, 4'd0, 4'd0);
        tick();
        issue_instruction = ins(4'b0101, 4'd8, 4'd3, 4'd3);
        repeat (2) tick();
        compared++;
        if (stall_cycles !== 16'd10 || stall !== 1'b1) begin
            mismatched++; $display("FAIL ar_pre got sc=%0d stall=%b want 10/1", stall_cycles, stall);
        end
        #2;
        resetn = 1'b0;
        #1;
        compared++;
        if (busy_mask !== 16'h0000 || stall_cycles !== 16'd0) begin
            mismatched++; $display("FAIL ar_state got busy=%h sc=%0d want 0000/0", busy_mask, stall_cycles);
        end
        compared++;
        if (issue_ready !== 1'b1 || underflow_err !== 1'b0) begin
            mismatched++; $display("FAIL ar_ready got rdy=%b uf=%b want 1/0", issue_ready, underflow_err);
        end
        issue_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_store();
        test_saturation();
        test_fire_retire();
        test_flush_underflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
